morse_receiver: RTL and testbench

Receive-side counterpart of the tick-rate blink transmitter. Samples a single on/off line (loopback from the blinker output or an optical sensor), recovers unit timing by re-aligning on every edge, classifies mark/space run lengths into Morse dots, dashes and gaps, and delivers one decoded letter per valid/ready transaction. It sits between the pin input and any downstream display or compare logic.

---
 rtl/morse_pkg.sv | 24 ++
 rtl/unit_sampler.sv | 48 ++++
 rtl/morse_receiver.sv | 155 +++++++++++++++
 tb/tb_morse_receiver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and thresholds for the Morse receive path.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE
  } state_t;

  localparam int unsigned DOT_MAX    = 2;
  localparam int unsigned LETTER_GAP = 2;
  localparam int unsigned WORD_GAP   = 6;

  localparam int unsigned MARK_W  = 3;
  localparam int unsigned SPACE_W = 4;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  function automatic logic element_of(input logic [MARK_W-1:0] cnt);
    return (cnt > MARK_W'(DOT_MAX)) ? DASH : DOT;
  endfunction

endpackage

// File: rtl/unit_sampler.sv
// Synchronizes the blink line, detects edges and strobes once per unit at mid-unit.
module unit_sampler #(
  parameter int unsigned TICK_RATE = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rise,
  output logic fall,
  output logic level,
  output logic strobe
);

  localparam int unsigned TW = $clog2(TICK_RATE);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_RATE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(TICK_RATE / 2);

  logic          sync0;
  logic          sync1;
  logic          prev;
  logic          edge_seen;
  logic [TW-1:0] tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
      tick  <= '0;
    end else begin
      sync0 <= rx;
      sync1 <= sync0;
      prev  <= sync1;
      // Every edge re-aligns the unit phase so sender clock drift never accumulates.
      if (edge_seen || tick == TICK_LAST) tick <= '0;
      else                                tick <= tick + 1'b1;
    end
  end

  always_comb begin
    level     = sync1;
    rise      = sync1 & ~prev;
    fall      = ~sync1 & prev;
    edge_seen = rise | fall;
    strobe    = (tick == TICK_MID) && !edge_seen;
  end

endmodule

// File: rtl/morse_receiver.sv
// Morse decoder: classifies mark/space runs into letters and word gaps, one symbol per handshake.
module morse_receiver
  import morse_pkg::*;
#(
  parameter int unsigned TICK_RATE    = 2500000,
  parameter int unsigned MAX_ELEMENTS = 6
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  RX,
  output logic                                  sym_valid,
  input  logic                                  sym_ready,
  output logic [$clog2(MAX_ELEMENTS+1)-1:0]     sym_len,
  output logic [MAX_ELEMENTS-1:0]               sym_bits,
  output logic                                  sym_word_end,
  output logic                                  sym_error,
  output logic                                  overrun,
  output logic                                  busy
);

  localparam int unsigned LW = $clog2(MAX_ELEMENTS + 1);

  logic rise;
  logic fall;
  logic level;
  logic strobe;

  unit_sampler #(
    .TICK_RATE(TICK_RATE)
  ) u_sampler (
    .clk   (CLK),
    .rst   (RST),
    .rx    (RX),
    .rise  (rise),
    .fall  (fall),
    .level (level),
    .strobe(strobe)
  );

  state_t               state;
  state_t               prior;
  logic [MARK_W-1:0]    mark_cnt;
  logic [SPACE_W-1:0]   space_cnt;
  logic [SPACE_W-1:0]   space_next;
  logic [LW-1:0]        acc_len;
  logic [MAX_ELEMENTS-1:0] acc_bits;
  logic                 acc_err;

  logic                 emit_letter;
  logic                 emit_word;
  logic                 emit;
  logic [LW-1:0]        e_len;
  logic [MAX_ELEMENTS-1:0] e_bits;
  logic                 e_word;
  logic                 e_err;

  always_comb begin
    space_next  = (space_cnt == '1) ? space_cnt : space_cnt + 1'b1;
    emit_letter = (state == SPACE) && !rise && strobe && (space_next == SPACE_W'(LETTER_GAP));
    emit_word   = (state == SPACE) && !rise && strobe && (space_next == SPACE_W'(WORD_GAP));
    emit        = emit_letter | emit_word;
    e_len       = emit_word ? '0 : acc_len;
    e_bits      = emit_word ? '0 : acc_bits;
    e_word      = emit_word;
    e_err       = emit_word ? 1'b0 : acc_err;
    busy        = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      prior     <= IDLE;
      mark_cnt  <= '0;
      space_cnt <= '0;
      acc_len   <= '0;
      acc_bits  <= '0;
      acc_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= MARK;
            prior    <= IDLE;
            mark_cnt <= '0;
          end
        end
        MARK: begin
          if (fall) begin
            // A mark shorter than one strobe is noise: resume exactly where we were.
            if (mark_cnt == '0) begin
              state <= prior;
            end else begin
              if (acc_len == LW'(MAX_ELEMENTS)) begin
                acc_err <= 1'b1;
              end else begin
                acc_bits[acc_len] <= element_of(mark_cnt);
                acc_len           <= acc_len + 1'b1;
              end
              state     <= SPACE;
              space_cnt <= '0;
            end
          end else if (strobe && level && mark_cnt != '1) begin
            mark_cnt <= mark_cnt + 1'b1;
          end
        end
        SPACE: begin
          if (rise) begin
            state    <= MARK;
            prior    <= SPACE;
            mark_cnt <= '0;
          end else if (strobe) begin
            space_cnt <= space_next;
            if (emit_letter) begin
              acc_len  <= '0;
              acc_bits <= '0;
              acc_err  <= 1'b0;
            end
            if (emit_word) begin
              state     <= IDLE;
              space_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sym_valid    <= 1'b0;
      sym_len      <= '0;
      sym_bits     <= '0;
      sym_word_end <= 1'b0;
      sym_error    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (emit) begin
        if (!sym_valid || sym_ready) begin
          sym_valid    <= 1'b1;
          sym_len      <= e_len;
          sym_bits     <= e_bits;
          sym_word_end <= e_word;
          sym_error    <= e_err;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_morse_receiver.sv
// Scoreboard bench for morse_receiver with directed unit-level blink patterns.
module tb_morse_receiver;

  localparam int TR   = 8;
  localparam int MAXE = 6;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX;
  logic       sym_valid;
  logic       sym_ready;
  logic [2:0] sym_len;
  logic [5:0] sym_bits;
  logic       sym_word_end;
  logic       sym_error;
  logic       overrun;
  logic       busy;

  morse_receiver #(
    .TICK_RATE   (TR),
    .MAX_ELEMENTS(MAXE)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX          (RX),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_len     (sym_len),
    .sym_bits    (sym_bits),
    .sym_word_end(sym_word_end),
    .sym_error   (sym_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] len;
    logic [5:0] bits;
    logic       we;
    logic       err;
  } sym_t;

  sym_t exp_q[$];
  int   checks   = 0;
  int   passed   = 0;
  int   overruns = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic push(input logic [2:0] len, input logic [5:0] bits, input logic we, input logic err);
    sym_t s;
    s = '{len: len, bits: bits, we: we, err: err};
    exp_q.push_back(s);
  endtask

  task automatic push_a(); push(3'd2, 6'b000010, 1'b0, 1'b0); endtask
  task automatic push_w(); push(3'd0, 6'b000000, 1'b1, 1'b0); endtask

  // Caller is positioned at posedge+1; each unit holds RX for TR cycles.
  task automatic unit(input logic v);
    RX = v;
    repeat (TR) @(posedge CLK);
    #1;
  endtask

  task automatic units(input logic [127:0] p, input int n);
    for (int i = 0; i < n; i++) unit(p[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) unit(1'b0);
  endtask

  // Monitor: pops the scoreboard on every completed handshake.
  always @(negedge CLK) begin
    if (!RST) begin
      if (overrun) overruns++;
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_symbol: got len=%0d bits=%b we=%b err=%b expected none",
                   sym_len, sym_bits, sym_word_end, sym_error);
        end else begin
          sym_t e;
          sym_t a;
          e = exp_q.pop_front();
          a = '{len: sym_len, bits: sym_bits, we: sym_word_end, err: sym_error};
          checks++;
          if (a === e) passed++;
          else $display("FAIL symbol: got len=%0d bits=%b we=%b err=%b expected len=%0d bits=%b we=%b err=%b",
                        a.len, a.bits, a.we, a.err, e.len, e.bits, e.we, e.err);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish expected done");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] pat;
    int           ov0;
    logic         seen_busy;

    RST = 1'b1;
    RX = 1'b0;
    sym_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check("reset_valid", {31'd0, sym_valid}, 32'd0);
    check("reset_len", {29'd0, sym_len}, 32'd0);
    check("reset_bits", {26'd0, sym_bits}, 32'd0);
    check("reset_flags", {29'd0, sym_word_end, sym_error, overrun}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Single A: dot, dash, trailing silence then word marker.
    push_a();
    push_w();
    units(128'b00011101, 8);
    idle(8);

    // Looped pattern: A W B W C W D W E, twice, then final word marker.
    pat = 128'b0001_000000000_0001010111_000000000_00010111010111_000000000_000101010111_000000000_00011101;
    for (int k = 0; k < 2; k++) begin
      push_a();                          push_w();
      push(3'd4, 6'b000001, 1'b0, 1'b0); push_w();
      push(3'd4, 6'b000101, 1'b0, 1'b0); push_w();
      push(3'd3, 6'b000001, 1'b0, 1'b0); push_w();
      push(3'd1, 6'b000000, 1'b0, 1'b0);
      units(pat, 84);
    end
    push_w();
    idle(8);
    check("loop_drained", exp_q.size(), 32'd0);

    // Back-pressure: E held, A dropped with one overrun pulse.
    ov0 = overruns;
    sym_ready = 1'b0;
    push(3'd1, 6'b000000, 1'b0, 1'b0);
    units(128'b0001, 4);
    units(128'b00011101, 8);
    check("held_valid", {31'd0, sym_valid}, 32'd1);
    check("held_len", {29'd0, sym_len}, 32'd1);
    check("held_bits", {26'd0, sym_bits}, 32'd0);
    check("overrun_once", overruns - ov0, 32'd1);
    sym_ready = 1'b1;
    push_w();
    idle(8);
    check("overrun_after_drain", overruns - ov0, 32'd1);

    // Seven dots overflow the six-element accumulator.
    push(3'd6, 6'b000000, 1'b0, 1'b1);
    push_w();
    units(128'b0001_0101_0101_0101, 16);
    idle(8);

    // Two-cycle glitch in IDLE is discarded.
    ov0 = overruns;
    seen_busy = 1'b0;
    RX = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RX = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      #1 if (busy) seen_busy = 1'b1;
    end
    check("glitch_entered_mark", {31'd0, seen_busy}, 32'd1);
    check("glitch_back_idle", {31'd0, busy}, 32'd0);
    idle(8);
    check("glitch_no_overrun", overruns - ov0, 32'd0);
    check("glitch_no_valid", {31'd0, sym_valid}, 32'd0);

    // Reset mid-letter discards the partial letter.
    units(128'b011101, 6);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_valid", {31'd0, sym_valid}, 32'd0);
    check("rst_len_bits", {23'd0, sym_len, sym_bits}, 32'd0);
    check("rst_flags", {28'd0, sym_word_end, sym_error, overrun, busy}, 32'd0);
    push(3'd1, 6'b000000, 1'b0, 1'b0);
    push_w();
    units(128'b0001, 4);
    idle(8);

    check("final_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
